// File: rtl/pio_in_pkg.sv
// pio_in_pkg: shared constants for the PIO input edge-capture slave.
//   Register word addresses, edge-select and interrupt-mode encodings.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_in_sync.sv
// pio_in_sync: WIDTH-wide two-flop synchronizer with a third history flop
// and a per-bit edge detector.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_port      : asynchronous input bits
//   s2           : synchronized input
//   edge_vec     : one-cycle pulse per bit on the selected edge (EDGE_TYPE)
module pio_in_sync
  import pio_in_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] edge_vec
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 trails s2 by one cycle, so each transition yields exactly one pulse.
  always_comb begin
    edge_vec = s2 & ~s3;
    if (EDGE_TYPE == EDGE_FALL)
      edge_vec = ~s2 & s3;
    else if (EDGE_TYPE == EDGE_ANY)
      edge_vec = s2 ^ s3;
  end

endmodule

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: Avalon-MM input PIO with edge capture and interrupt.
//   clk, reset_n      : clock, asynchronous active-low reset
//   address           : 0 data (RO), 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect, read_n, write_n, writedata : slave bus
//   in_port           : asynchronous input pins
//   readdata          : registered read data, holds between reads
//   irq               : active-high interrupt
// Build option: define PIO_IN_BITCLEAR_EN so an edgecapture write clears
// only the bits written as 1; otherwise any such write clears every bit.
module pio_in_edge_capture
  import pio_in_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int EDGE_TYPE = EDGE_RISE,
  parameter int IRQ_TYPE  = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             ecap_clr;
  logic             unused_wdata;

  pio_in_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .s2       (s2),
    .edge_vec (edge_vec)
  );

  assign wr_en    = chipselect & ~write_n;
  assign rd_en    = chipselect & ~read_n;
  assign ecap_clr = wr_en && (address == ADDR_EDGECAP);

`ifdef PIO_IN_BITCLEAR_EN
  assign clear_mask = ecap_clr ? writedata[WIDTH-1:0] : '0;
`else
  assign clear_mask = ecap_clr ? {WIDTH{1'b1}} : '0;
`endif

  // Upper writedata bits have no destination.
  assign unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && (address == ADDR_IRQMASK))
        irqmask <= writedata[WIDTH-1:0];
      // New edges are OR-ed in after the clear, so an edge wins a collision.
      edgecapture <= (edgecapture & ~clear_mask) | edge_vec;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = s2;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else if (rd_en)
      readdata <= rd_mux;
  end

  generate
    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
      assign irq = |(s2 & irqmask);
    end else begin : g_irq_edge
      assign irq = |(edgecapture & irqmask);
    end
  endgenerate

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Bench for pio_in_edge_capture: a default instance (rising edge, edge irq)
// and a second instance (any edge, level irq) share the bus and in_port.
module tb_pio_in_edge_capture;
  import pio_in_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [4:0]  in_port = '0;
  logic [31:0] readdata, readdata_lvl;
  logic        irq, irq_lvl;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  in_val;
    logic [31:0] exp_ecap;
    logic        exp_irq;
    logic [31:0] exp_any;
    logic        exp_lvl_irq;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic        chk_lvl;
    logic [31:0] exp_lvl;
  } sb_t;

  vec_t tbl[7];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  pio_in_edge_capture dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  pio_in_edge_capture #(.WIDTH(5), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_LEVEL)) dut_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata_lvl), .irq(irq_lvl)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] e,
                         input logic cl, input logic [31:0] el, input string nm);
    sb_t ent;
    address = a; chipselect = 1'b1; read_n = 1'b0;
    sbq.push_back('{nm, e, cl, el});
    cyc();
    chipselect = 1'b0; read_n = 1'b1;
    ent = sbq.pop_front();
    check(ent.name, readdata, ent.exp);
    if (ent.chk_lvl) check({ent.name, "_lvl"}, readdata_lvl, ent.exp_lvl);
  endtask

  task automatic settle_and_clear(input logic [4:0] v);
    in_port = v;
    repeat (3) cyc();
    do_write(ADDR_EDGECAP, 32'h1F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_clr;

    tbl[0] = '{5'h01, 32'h01, 1'b1, 32'h01, 1'b1};
    tbl[1] = '{5'h00, 32'h00, 1'b0, 32'h01, 1'b0};
    tbl[2] = '{5'h15, 32'h15, 1'b1, 32'h15, 1'b1};
    tbl[3] = '{5'h14, 32'h00, 1'b0, 32'h01, 1'b0};
    tbl[4] = '{5'h1F, 32'h0B, 1'b1, 32'h0B, 1'b1};
    tbl[5] = '{5'h02, 32'h00, 1'b0, 32'h1D, 1'b0};
    tbl[6] = '{5'h1C, 32'h1C, 1'b0, 32'h1E, 1'b0};

    // Reset state
    #2;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_irq_lvl", {31'd0, irq_lvl}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc();
    do_read(ADDR_DATA, 32'h0, 1'b1, 32'h0, "rst_data");
    do_read(ADDR_IRQMASK, 32'h0, 1'b1, 32'h0, "rst_mask");
    do_read(ADDR_EDGECAP, 32'h0, 1'b1, 32'h0, "rst_ecap");

    // Register map
    do_write(ADDR_RSVD, 32'hFFFF_FFFF);
    do_read(ADDR_RSVD, 32'h0, 1'b1, 32'h0, "rsvd");
    do_write(ADDR_IRQMASK, 32'hFFFF_FFE3);
    do_read(ADDR_IRQMASK, 32'h03, 1'b1, 32'h03, "mask_trunc");
    do_write(ADDR_IRQMASK, 32'h01);

    // Table-driven edge capture
    for (int i = 0; i < 7; i++) begin
      in_port = tbl[i].in_val;
      repeat (3) cyc();
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      check($sformatf("tbl%0d_irq_lvl", i), {31'd0, irq_lvl}, {31'd0, tbl[i].exp_lvl_irq});
      do_read(ADDR_EDGECAP, tbl[i].exp_ecap, 1'b1, tbl[i].exp_any, $sformatf("tbl%0d_ecap", i));
      do_read(ADDR_DATA, {27'd0, tbl[i].in_val}, 1'b0, 32'h0, $sformatf("tbl%0d_data", i));
      do_write(ADDR_EDGECAP, 32'h1F);
      check($sformatf("tbl%0d_hold", i), readdata, {27'd0, tbl[i].in_val});
    end

    // Sync latency
    settle_and_clear(5'h00);
    in_port = 5'h15;
    do_read(ADDR_DATA, 32'h00, 1'b0, 32'h0, "sync_early");
    cyc();
    do_read(ADDR_DATA, 32'h15, 1'b0, 32'h0, "sync_late");

    // Clear semantics
    settle_and_clear(5'h00);
    in_port = 5'h03;
    repeat (3) cyc();
    do_read(ADDR_EDGECAP, 32'h03, 1'b0, 32'h0, "clr_pre");
    do_write(ADDR_EDGECAP, 32'h01);
`ifdef PIO_IN_BITCLEAR_EN
    exp_clr = 32'h02;
`else
    exp_clr = 32'h00;
`endif
    do_read(ADDR_EDGECAP, exp_clr, 1'b0, 32'h0, "clr_post");

    // Edge and clear colliding on bit 2
    settle_and_clear(5'h00);
    do_write(ADDR_IRQMASK, 32'h04);
    in_port = 5'h04;
    repeat (2) cyc();
    do_write(ADDR_EDGECAP, 32'h04);
    check("coll_irq", {31'd0, irq}, 32'h1);
    do_read(ADDR_EDGECAP, 32'h04, 1'b0, 32'h0, "coll_ecap");

    // Level interrupt latency
    settle_and_clear(5'h00);
    do_write(ADDR_IRQMASK, 32'h10);
    in_port = 5'h10;
    cyc();
    check("lvl_rise_1", {31'd0, irq_lvl}, 32'h0);
    cyc();
    check("lvl_rise_2", {31'd0, irq_lvl}, 32'h1);
    in_port = 5'h00;
    cyc();
    check("lvl_fall_1", {31'd0, irq_lvl}, 32'h1);
    cyc();
    check("lvl_fall_2", {31'd0, irq_lvl}, 32'h0);

    // Asynchronous reset mid-cycle
    settle_and_clear(5'h00);
    do_write(ADDR_IRQMASK, 32'h1F);
    in_port = 5'h1F;
    repeat (3) cyc();
    do_read(ADDR_EDGECAP, 32'h1F, 1'b0, 32'h0, "arst_pre");
    check("arst_pre_irq", {31'd0, irq}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'h0);
    check("arst_irq_lvl", {31'd0, irq_lvl}, 32'h0);
    check("arst_readdata", readdata, 32'h0);
    in_port = 5'h00;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (4) cyc();
    check("arst_rel_irq", {31'd0, irq}, 32'h0);
    do_read(ADDR_EDGECAP, 32'h0, 1'b1, 32'h0, "arst_ecap");
    do_read(ADDR_IRQMASK, 32'h0, 1'b1, 32'h0, "arst_mask");
    do_read(ADDR_DATA, 32'h0, 1'b1, 32'h0, "arst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_capture.md
PIO_IN_EDGE_CAPTURE -- requirements
Module: pio_in_edge_capture

Interface
REQ-001 Parameter WIDTH, default 5: in_port width, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: capture edge; 0 rising, 1 falling, 2 any.
REQ-003 Parameter IRQ_TYPE, default 1: 0 level (synchronized data), 1 edge (edge-capture).
REQ-004 Port clk  in  1  clock; all state updates on rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 Port address  in  2  Avalon-MM word address.
REQ-007 Port chipselect  in  1  slave select.
REQ-008 Port read_n  in  1  active-low read strobe.
REQ-009 Port write_n  in  1  active-low write strobe.
REQ-010 Port writedata  in  32  write data.
REQ-011 Port in_port  in  WIDTH  asynchronous FPGA-side input.
REQ-012 Port readdata  out  32  registered read data.
REQ-013 Port irq  out  1  active-high interrupt request.

Function
REQ-014 Register map SHALL be: 0 data (RO), 1 reserved (reads 0, writes ignored), 2 irqmask (RW), 3 edgecapture (read / write-to-clear).
REQ-015 in_port SHALL pass a 2-flop synchronizer (s1, s2); a third flop s3 SHALL hold the previous s2.
REQ-016 Edge detect per bit: rising = s2 & ~s3, falling = ~s2 & s3, any = s2 ^ s3, selected by EDGE_TYPE.
REQ-017 in_port change settling before clk edge k SHALL set the edgecapture bit at edge k+2, readable one cycle later.
REQ-018 A detected edge SHALL set its edgecapture bit, which stays set until cleared by a write to address 3.
REQ-019 An edge and a clear of the same bit in the same cycle: the bit SHALL end set.
REQ-020 Write to address 2 SHALL load irqmask = writedata[WIDTH-1:0]; bits above WIDTH ignored.
REQ-021 A read (chipselect & ~read_n) at edge k SHALL present the addressed register, zero-extended to 32 bits, on readdata after edge k; readdata SHALL hold its value otherwise.
REQ-022 Data read SHALL return s2, not raw in_port.
REQ-023 IRQ_TYPE 1: irq = |(edgecapture & irqmask); IRQ_TYPE 0: irq = |(s2 & irqmask); irq is combinational from registers, with no extra latency.
REQ-024 Reads SHALL have no side effects; simultaneous chipselect with read_n and write_n both low SHALL perform both.

Reset
REQ-025 While reset_n is low, s1, s2, s3, edgecapture, irqmask and readdata SHALL be 0, and irq SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL clear pending captures immediately; release SHALL not produce a spurious edge while in_port is 0.

Configuration
REQ-027 Macro PIO_IN_BITCLEAR_EN defined: a write to address 3 SHALL clear only the bits where writedata is 1.
REQ-028 Macro PIO_IN_BITCLEAR_EN undefined: any write to address 3 SHALL clear all edgecapture bits, regardless of writedata.

Structure
REQ-029 Package pio_in_pkg SHALL hold the register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and the EDGE_RISE/EDGE_FALL/EDGE_ANY and IRQ_LEVEL/IRQ_EDGE constants.
REQ-030 Sub-module pio_in_sync (WIDTH-wide synchronizer plus edge detector, outputs s2 and edge vector) SHALL be instantiated once.

Verification
REQ-031 Sync latency: in_port 0x00 -> 0x15 then read address 0 -> readdata 0x15 only on reads issued at or after the 2nd clk edge following the change.
REQ-032 Rising capture: EDGE_TYPE 0, irqmask 0x01, pulse in_port[0] high for 3 cycles -> edgecapture 0x01, irq 1; a falling edge alone sets nothing.
REQ-033 Clear: with PIO_IN_BITCLEAR_EN, edgecapture 0x03 and a write of 0x01 to address 3 -> edgecapture 0x02; without the macro, the same write -> 0x00.
REQ-034 Collision: a rising edge on bit 2 in the same cycle as a clear write 0x04 -> edgecapture bit 2 remains 1, irq stays asserted if masked.
REQ-035 Level IRQ: IRQ_TYPE 0, irqmask 0x10, in_port 0x10 -> irq 1 after 2 cycles; in_port 0x00 -> irq 0 after 2 cycles.
REQ-036 Async reset: reset_n pulled low mid-cycle with edgecapture 0x1F, irqmask 0x1F -> irq and all registers 0 before the next clk edge.
